bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-002 SHALL have port clear, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-004 SHALL have ports bcd2, bcd1, bcd0, input, 4 bits each: hundreds, tens and units digits.
REQ-005 SHALL have port bin, output, 10 bits: binary result, held until the next result.
REQ-006 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when bin/err update.
REQ-008 SHALL have port err, output, 1 bit: invalid-digit flag, held with bin.

Function
REQ-009 SHALL implement FSM states IDLE, CHECK, SHIFT, DONE.
REQ-010 In IDLE, start=1 SHALL capture {bcd2,bcd1,bcd0} into a 22-bit work register {bcd[11:0], acc[9:0]=0} and move to CHECK.
REQ-011 CHECK SHALL take one cycle; if any captured digit >9, next state SHALL be DONE with bin=0 and err=1; otherwise SHIFT.
REQ-012 SHIFT SHALL run exactly 10 cycles via a 4-bit iteration counter.
REQ-013 Each SHIFT cycle SHALL shift the work register right by 1, then subtract 3 from each BCD nibble whose post-shift value is >=8.
REQ-014 After the 10th SHIFT cycle, next state SHALL be DONE; acc SHALL equal 100*bcd2+10*bcd1+bcd0, and the BCD field SHALL be 0.
REQ-015 DONE SHALL last one cycle with done=1, load bin from acc (err=0), then return to IDLE.
REQ-016 Latency SHALL be 12 rising edges for a valid conversion and 2 for an invalid one, counted from the edge sampling start to the first cycle in which done is visible.
REQ-017 start while busy=1 SHALL be ignored with no queuing; start in the same cycle as DONE SHALL also be ignored.
REQ-018 Input digits SHALL NOT be re-sampled after capture; changes during busy SHALL have no effect.
REQ-019 A new start in IDLE SHALL clear err only when the new result loads in DONE.

Reset
REQ-020 clear=0 at a rising edge SHALL force IDLE and set bin=0, err=0, done=0, busy=0, counter=0, and clear the work register.
REQ-021 clear mid-conversion SHALL abort with no done pulse; clear has priority over start.

Configuration
REQ-022 Macro BCD_TO_BIN_DIGIT_CHECK_EN defined SHALL enable the CHECK validity test and err behaviour per REQ-011.
REQ-023 Macro BCD_TO_BIN_DIGIT_CHECK_EN undefined SHALL tie err to 0, make CHECK always go to SHIFT, and convert invalid digits by the same arithmetic without flagging.

Structure
REQ-024 Package bcd_pkg SHALL hold the state enum, DIGITS=3, BIN_W=10, BCD_W=12, and ITERS=10.
REQ-025 Sub-module bcd_nibble_adj (combinational; 4-bit in/out; subtract 3 if >=8) SHALL be instantiated once per digit.

Verification
REQ-026 clear low 2 cycles, then high -> bin=0, done=0, busy=0, err=0.
REQ-027 start with digits 9,9,9 -> done pulse 12 edges later, bin=999 (10'h3E7), err=0.
REQ-028 Exhaustive 000..999, back-to-back starts -> bin equals decimal value every time.
REQ-029 bcd1=4'hA, start -> done after 2 edges, bin=0, err=1 (macro on); with macro off, err=0.
REQ-030 start 1,2,3, then re-pulse start and change digits at cycles 3 and 12 -> single result bin=123.
REQ-031 start 5,0,0, clear low at cycle 6 -> no done, IDLE; new start 0,4,2 -> bin=42.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and sizes for the 3-digit BCD to 10-bit binary converter.
package bcd_pkg;

    localparam int unsigned DIGITS = 3;
    localparam int unsigned BIN_W  = 10;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned ITERS  = 10;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORK_W = BCD_W + BIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // A BCD digit is only legal in the range 0..9.
    function automatic logic digit_invalid(input logic [NIB_W-1:0] d);
        return d > NIB_W'(9);
    endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Reverse double-dabble correction for one BCD nibble: subtract 3 when >= 8.
module bcd_nibble_adj
    import bcd_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [NIB_W-1:0] nib_o
);

    // Undo the weight-10 carry that a right shift drags into the nibble.
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= NIB_W'(8)) begin
            nib_o = nib_i - NIB_W'(3);
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to binary converter (shift-right / subtract-3).
// Optional digit validity check and err flag: define BCD_TO_BIN_DIGIT_CHECK_EN.
module bcd_to_bin
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [NIB_W-1:0] bcd2,
    input  logic [NIB_W-1:0] bcd1,
    input  logic [NIB_W-1:0] bcd0,
    output logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [WORK_W-1:0]   shifted_c;
    logic [BCD_W-1:0]    bcd_adj_c;
    logic [WORK_W-1:0]   work_step_c;
    logic                bad_digit_c;

    // One shift step of the work register, before the nibble correction.
    assign shifted_c = work_q >> 1;

    // Per-digit correction applied to the post-shift BCD field.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib_i (shifted_c[BIN_W + g*NIB_W +: NIB_W]),
            .nib_o (bcd_adj_c[g*NIB_W +: NIB_W])
        );
    end

    assign work_step_c = {bcd_adj_c, shifted_c[BIN_W-1:0]};

    // Flag any captured digit outside 0..9 (constant 0 when checking is off).
    always_comb begin
        bad_digit_c = 1'b0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        for (int i = 0; i < DIGITS; i++) begin
            bad_digit_c = bad_digit_c | digit_invalid(work_q[BIN_W + i*NIB_W +: NIB_W]);
        end
`else
        bad_digit_c = 1'b0;
`endif
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {bcd2, bcd1, bcd0, BIN_W'(0)};
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (bad_digit_c) begin
                    bin_d   = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = work_step_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    cnt_d   = '0;
                    bin_d   = work_step_c[BIN_W-1:0];
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bin  = bin_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin.
module tb_bcd_to_bin;

    logic       clk;
    logic       clear;
    logic       start;
    logic [3:0] bcd2, bcd1, bcd0;
    logic [9:0] bin;
    logic       busy, done, err;

    int n_checks;
    int n_fail;

    bcd_to_bin dut (
        .clk   (clk),
        .clear (clear),
        .start (start),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start and return edges from the sampling edge until done is seen.
    task automatic run_conv(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                            output int edges, output logic got, output logic busy_ok);
        @(negedge clk);
        bcd2 = d2; bcd1 = d1; bcd0 = d0; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start   = 1'b0;
        busy_ok = 1'b1;
        while (!done && edges < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        got = (done === 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear = 1'b0; start = 1'b1;
        bcd2 = 4'd1; bcd1 = 4'd2; bcd0 = 4'd3;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_over_start busy=%b want 0", busy); end
        clear = 1'b1; start = 1'b0;
        @(negedge clk);
        n_checks++; if (bin !== 10'd0)  begin n_fail++; $display("FAIL reset_bin bin=%0d want 0", bin); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done done=%b want 0", done); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy busy=%b want 0", busy); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err err=%b want 0", err); end
    endtask

    task automatic test_max();
        int edges; logic got, bok;
        run_conv(4'd9, 4'd9, 4'd9, edges, got, bok);
        n_checks++; if (!got)           begin n_fail++; $display("FAIL max_done_timeout got=%b want 1", got); end
        n_checks++; if (edges !== 12)   begin n_fail++; $display("FAIL max_latency edges=%0d want 12", edges); end
        n_checks++; if (bin !== 10'h3E7) begin n_fail++; $display("FAIL max_bin bin=%0d want 999", bin); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL max_err err=%b want 0", err); end
        n_checks++; if (!bok)           begin n_fail++; $display("FAIL max_busy busy_ok=%b want 1", bok); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL done_pulse_width done=%b want 0", done); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL idle_after_done busy=%b want 0", busy); end
        repeat (3) @(negedge clk);
        n_checks++; if (bin !== 10'd999) begin n_fail++; $display("FAIL bin_hold bin=%0d want 999", bin); end
    endtask

    task automatic test_vectors();
        logic [3:0] v2 [4] = '{4'd0, 4'd1, 4'd5, 4'd2};
        logic [3:0] v1 [4] = '{4'd0, 4'd0, 4'd1, 4'd5};
        logic [3:0] v0 [4] = '{4'd0, 4'd0, 4'd2, 4'd6};
        int       exp  [4] = '{0, 100, 512, 256};
        int edges; logic got, bok;
        for (int i = 0; i < 4; i++) begin
            run_conv(v2[i], v1[i], v0[i], edges, got, bok);
            n_checks++;
            if (!got || bin !== 10'(exp[i]) || edges !== 12) begin
                n_fail++;
                $display("FAIL vector_%0d bin=%0d edges=%0d want bin=%0d edges=12", i, bin, edges, exp[i]);
            end
        end
    endtask

    task automatic test_invalid();
        int edges; logic got, bok;
        run_conv(4'd0, 4'hA, 4'd0, edges, got, bok);
        n_checks++; if (!got) begin n_fail++; $display("FAIL invalid_timeout got=%b want 1", got); end
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        n_checks++; if (edges !== 2)   begin n_fail++; $display("FAIL invalid_latency edges=%0d want 2", edges); end
        n_checks++; if (bin !== 10'd0) begin n_fail++; $display("FAIL invalid_bin bin=%0d want 0", bin); end
        n_checks++; if (err !== 1'b1)  begin n_fail++; $display("FAIL invalid_err err=%b want 1", err); end
        // err stays until the next valid result loads
        @(negedge clk);
        bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (err !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL err_held err=%b busy=%b want 1 1", err, busy); end
        edges = 0;
        while (!done && edges < 40) begin @(negedge clk); edges++; end
        n_checks++; if (err !== 1'b0 || bin !== 10'd7) begin n_fail++; $display("FAIL err_cleared err=%b bin=%0d want 0 7", err, bin); end
`else
        n_checks++; if (edges !== 12)  begin n_fail++; $display("FAIL invalid_nocheck_latency edges=%0d want 12", edges); end
        n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL invalid_nocheck_err err=%b want 0", err); end
`endif
    endtask

    task automatic test_ignore_start();
        int n_done; int done_k; logic [9:0] got_bin;
        @(negedge clk);
        bcd2 = 4'd1; bcd1 = 4'd2; bcd0 = 4'd3; start = 1'b1;
        @(posedge clk);
        n_done = 0; done_k = 0; got_bin = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin n_done++; done_k = k; got_bin = bin; end
            start = (k == 2 || k == 11 || k == 12) ? 1'b1 : 1'b0;
            if (k == 2 || k == 11) begin bcd2 = 4'd9; bcd1 = 4'd8; bcd0 = 4'd7; end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (n_done !== 1)       begin n_fail++; $display("FAIL ignore_single_done count=%0d want 1", n_done); end
        n_checks++; if (done_k !== 12)      begin n_fail++; $display("FAIL ignore_latency edge=%0d want 12", done_k); end
        n_checks++; if (got_bin !== 10'd123) begin n_fail++; $display("FAIL ignore_bin bin=%0d want 123", got_bin); end
    endtask

    task automatic test_clear_abort();
        int edges; logic got, bok; int n_done;
        @(negedge clk);
        bcd2 = 4'd5; bcd1 = 4'd0; bcd0 = 4'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || bin !== 10'd0) begin
            n_fail++; $display("FAIL abort_state busy=%b done=%b bin=%0d want 0 0 0", busy, done, bin);
        end
        n_done = 0;
        repeat (15) begin @(negedge clk); if (done === 1'b1) n_done++; end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done count=%0d want 0", n_done); end
        run_conv(4'd0, 4'd4, 4'd2, edges, got, bok);
        n_checks++; if (!got || bin !== 10'd42 || edges !== 12) begin
            n_fail++; $display("FAIL after_abort bin=%0d edges=%0d want 42 12", bin, edges);
        end
    endtask

    task automatic test_back_to_back();
        int edges; logic got, bok; int bad; int v;
        bad = 0;
        for (int d2 = 0; d2 < 10; d2++) begin
            for (int d1 = 0; d1 < 10; d1++) begin
                for (int d0 = 0; d0 < 10; d0++) begin
                    v = 100*d2 + 10*d1 + d0;
                    run_conv(4'(d2), 4'(d1), 4'(d0), edges, got, bok);
                    n_checks++;
                    if (!got || bin !== 10'(v) || edges !== 12 || err !== 1'b0) begin
                        n_fail++;
                        if (bad < 5) $display("FAIL exhaustive_%0d bin=%0d edges=%0d err=%b want %0d 12 0", v, bin, edges, err, v);
                        bad++;
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear = 1'b0; start = 1'b0;
        bcd2 = '0; bcd1 = '0; bcd0 = '0;
        test_reset();
        test_max();
        test_vectors();
        test_invalid();
        test_ignore_start();
        test_clear_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
